// File: rtl/ctrl_pkg.sv
// Shared control encodings for the 16-bit multi-cycle datapath: FSM states,
// opcodes and the select/AluOp codes also consumed by the ALU and register block.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_ADDI  = 4'h4,
    OP_LI    = 4'h5,
    OP_LW    = 4'h6,
    OP_SW    = 4'h7,
    OP_SLT   = 4'h8,
    OP_BNZ   = 4'h9,
    OP_JAL   = 4'hA,
    OP_JR    = 4'hB,
    OP_MV    = 4'hC,
    OP_ADDSP = 4'hD,
    OP_ILL_E = 4'hE,
    OP_ILL_F = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_PASSB = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_SHELLEY = 2'd0,
    SRCB_ZEXT    = 2'd1,
    SRCB_SEXT    = 2'd2,
    SRCB_SEXT_LS = 2'd3
  } src_b_e;

  typedef enum logic {
    SRCA_MARY = 1'b0,
    SRCA_SP   = 1'b1
  } src_a_e;

  typedef enum logic [1:0] {
    MARY_SRC_ALU     = 2'd0,
    MARY_SRC_MEM     = 2'd1,
    MARY_SRC_IMM     = 2'd2,
    MARY_SRC_SHELLEY = 2'd3
  } mary_src_e;

  typedef enum logic [1:0] {
    SHELLEY_SRC_ALU  = 2'd0,
    SHELLEY_SRC_MEM  = 2'd1,
    SHELLEY_SRC_MARY = 2'd2
  } shelley_src_e;

  typedef enum logic [1:0] {
    PC_SRC_PLUS2  = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_RA     = 2'd2
  } pc_src_e;

  typedef enum logic {
    ADDR_SRC_PC  = 1'b0,
    ADDR_SRC_ALU = 1'b1
  } addr_src_e;

  typedef enum logic {
    RA_SRC_PC  = 1'b0,
    RA_SRC_ALU = 1'b1
  } ra_src_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       sp_write;
    logic [1:0] pc_src;
    logic       mary_write;
    logic       shelley_write;
    logic       comp_write;
    logic       ra_write;
    logic [1:0] mary_src;
    logic [1:0] shelley_src;
    logic       ra_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic       halted;
  } ctrl_out_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILL_E) || (op == OP_ILL_F);
  endfunction

  // Only signed add/subtract results into mary can overflow and must be suppressed.
  function automatic logic is_overflow_checked(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI};
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode: maps state and latched opcode to every
// strobe, enable and select driven toward memory, the ALU and the register block.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       i_reset,
  input  state_e     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_overflow,
  input  logic       i_comp_nonzero,
  input  logic       i_mem_ready,
  output ctrl_out_t  o_ctrl
);

  logic w_ovf_abort;

  assign w_ovf_abort = is_overflow_checked(i_opcode) && i_overflow;

  // NOTE: o_ctrl is fully defaulted first so no path through the cases infers a latch.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read     = 1'b1;
        o_ctrl.mem_addr_src = ADDR_SRC_PC;
        o_ctrl.ir_write     = i_mem_ready;
        o_ctrl.pc_write     = i_mem_ready;
        o_ctrl.pc_src       = PC_SRC_PLUS2;
      end
      ST_EXEC: begin
        case (i_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            // R-type opcodes are numbered to match their AluOp codes.
            o_ctrl.src_a      = SRCA_MARY;
            o_ctrl.src_b      = SRCB_SHELLEY;
            o_ctrl.alu_op     = i_opcode;
            o_ctrl.mary_src   = MARY_SRC_ALU;
            o_ctrl.mary_write = !w_ovf_abort;
          end
          OP_ADDI: begin
            o_ctrl.src_b      = SRCB_SEXT;
            o_ctrl.alu_op     = ALU_ADD;
            o_ctrl.mary_src   = MARY_SRC_ALU;
            o_ctrl.mary_write = !w_ovf_abort;
          end
          OP_LI: begin
            o_ctrl.mary_src   = MARY_SRC_IMM;
            o_ctrl.mary_write = 1'b1;
          end
          OP_LW, OP_SW: begin
            o_ctrl.src_b  = SRCB_SEXT;
            o_ctrl.alu_op = ALU_ADD;
          end
          OP_SLT: begin
            o_ctrl.alu_op     = ALU_SLT;
            o_ctrl.comp_write = 1'b1;
          end
          OP_BNZ: begin
            o_ctrl.pc_write = i_comp_nonzero;
            o_ctrl.pc_src   = PC_SRC_BRANCH;
          end
          OP_JAL: begin
            o_ctrl.ra_write = 1'b1;
            o_ctrl.ra_src   = RA_SRC_PC;
            o_ctrl.pc_write = 1'b1;
            o_ctrl.pc_src   = PC_SRC_BRANCH;
          end
          OP_JR: begin
            o_ctrl.pc_write = 1'b1;
            o_ctrl.pc_src   = PC_SRC_RA;
          end
          OP_MV: begin
            o_ctrl.shelley_write = 1'b1;
            o_ctrl.shelley_src   = SHELLEY_SRC_MARY;
          end
          OP_ADDSP: begin
            o_ctrl.src_a    = SRCA_SP;
            o_ctrl.src_b    = SRCB_SEXT_LS;
            o_ctrl.alu_op   = ALU_ADD;
            o_ctrl.sp_write = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // Effective address stays on aluout, so the ALU controls are held from EXEC.
        o_ctrl.mem_read     = (i_opcode == OP_LW);
        o_ctrl.mem_write    = (i_opcode == OP_SW);
        o_ctrl.mem_addr_src = ADDR_SRC_ALU;
        o_ctrl.src_b        = SRCB_SEXT;
        o_ctrl.alu_op       = ALU_ADD;
      end
      ST_WB: begin
        o_ctrl.mary_write = 1'b1;
        o_ctrl.mary_src   = MARY_SRC_MEM;
      end
      ST_TRAP: begin
        o_ctrl.halted = 1'b1;
      end
      default: ;
    endcase

    if (i_reset) begin
      o_ctrl = '0;
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback and
// owns the state register, the latched opcode and the memory-wait timeout.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        overflow,
  input  logic        comp_nonzero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        sp_write,
  output logic [1:0]  pc_src,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        comp_write,
  output logic        ra_write,
  output logic [1:0]  mary_src,
  output logic [1:0]  shelley_src,
  output logic        ra_src,
  output logic        SrcA,
  output logic [1:0]  SrcB,
  output logic [3:0]  AluOp,
  output logic        halted,
  output logic [2:0]  state
);

  localparam int CW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);

  state_e        r_state;
  state_e        w_next_state;
  logic [3:0]    r_opcode;
  logic [CW-1:0] r_count;
  logic          w_waiting;
  logic          w_timeout;
  logic          w_unused_imm;
  ctrl_out_t     w_ctrl;

  // Immediate fields feed the datapath directly; only the opcode matters here.
  assign w_unused_imm = ^instr[11:0];

  always_comb begin
    w_waiting    = 1'b0;
    w_timeout    = 1'b0;
    w_next_state = r_state;

    if ((r_state == ST_FETCH) || (r_state == ST_MEM)) begin
      w_waiting = !mem_ready;
      w_timeout = w_waiting && (FETCH_TIMEOUT != 0) &&
                  ((int'(r_count) + 1) == FETCH_TIMEOUT);
    end

    case (r_state)
      ST_FETCH: begin
        if (mem_ready)      w_next_state = ST_DECODE;
        else if (w_timeout) w_next_state = ST_TRAP;
      end
      ST_DECODE: begin
        w_next_state = is_illegal(instr[15:12]) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if (is_overflow_checked(r_opcode) && overflow) w_next_state = ST_TRAP;
        else if (is_mem_op(r_opcode))                  w_next_state = ST_MEM;
        else                                           w_next_state = ST_FETCH;
      end
      ST_MEM: begin
        if (mem_ready)      w_next_state = (r_opcode == OP_LW) ? ST_WB : ST_FETCH;
        else if (w_timeout) w_next_state = ST_TRAP;
      end
      ST_WB:   w_next_state = ST_FETCH;
      ST_TRAP: w_next_state = ST_TRAP;
      default: w_next_state = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_FETCH;
      r_opcode <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE) begin
        r_opcode <= instr[15:12];
      end
      if (w_next_state != r_state) begin
        r_count <= '0;
      end else if (w_waiting) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  ctrl_decode u_decode (
    .i_reset        (reset),
    .i_state        (r_state),
    .i_opcode       (r_opcode),
    .i_overflow     (overflow),
    .i_comp_nonzero (comp_nonzero),
    .i_mem_ready    (mem_ready),
    .o_ctrl         (w_ctrl)
  );

  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign mem_addr_src  = w_ctrl.mem_addr_src;
  assign ir_write      = w_ctrl.ir_write;
  assign pc_write      = w_ctrl.pc_write;
  assign sp_write      = w_ctrl.sp_write;
  assign pc_src        = w_ctrl.pc_src;
  assign mary_write    = w_ctrl.mary_write;
  assign shelley_write = w_ctrl.shelley_write;
  assign comp_write    = w_ctrl.comp_write;
  assign ra_write      = w_ctrl.ra_write;
  assign mary_src      = w_ctrl.mary_src;
  assign shelley_src   = w_ctrl.shelley_src;
  assign ra_src        = w_ctrl.ra_src;
  assign SrcA          = w_ctrl.src_a;
  assign SrcB          = w_ctrl.src_b;
  assign AluOp         = w_ctrl.alu_op;
  assign halted        = w_ctrl.halted;
  assign state         = r_state;

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control unit for the 16-bit datapath. It is the initiator side of the register/ALU control interface: it drives every write-enable, source-select and AluOp strobe that the register block and ALU consume.
- Sequences fetch, decode, execute, memory and writeback for each instruction. Handshakes with instruction/data memory and halts on an illegal opcode or arithmetic overflow.

Parameters:
- FETCH_TIMEOUT, 255: number of cycles with mem_ready low in FETCH or MEM before entering TRAP; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instr  in  16  instruction register contents; opcode = instr[15:12]
- overflow  in  1  ALU overflow, combinational, same cycle
- comp_nonzero  in  1  comp register != 0
- mem_ready  in  1  memory completes the current access this cycle
- mem_read, mem_write  out  1  memory request strobes, held until mem_ready
- mem_addr_src  out  1  0 = pc, 1 = aluout
- ir_write, pc_write, sp_write  out  1  register enables
- pc_src  out  2  0 = pc+2, 1 = pc+sext_ls_imm, 2 = ra
- mary_write, shelley_write, comp_write, ra_write  out  1  register-block enables
- mary_src  out  2  0 = aluout, 1 = memval, 2 = sext immediate, 3 = shelley
- shelley_src  out  2  0 = aluout, 1 = memval, 2 = mary
- ra_src  out  1  0 = pc, 1 = aluout
- SrcA  out  1  0 = mary, 1 = sp
- SrcB  out  2  0 = shelley, 1 = zext_imm, 2 = sext_imm, 3 = sext_ls_imm
- AluOp  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 PASSB
- halted  out  1  sticky; set in TRAP
- state  out  3  current state, for debug

Behaviour:
- Reset: state = FETCH, halted = 0, timeout counter = 0. Every strobe and enable output is 0 during and after the reset cycle. Select outputs are 0.
- Reset asserted in any state, including mid-MEM, aborts the access; the next cycle is a fresh FETCH.
- Outputs are Moore, decoded from state and the opcode latched in DECODE. The single exception is the overflow gating described under EXEC.
- FETCH:
  - mem_read = 1, mem_addr_src = 0.
  - On mem_ready: ir_write = 1, pc_write = 1 with pc_src = 0, then go to DECODE.
  - Otherwise stay in FETCH and increment the timeout counter.
- DECODE: latch the opcode. Opcodes 0xE and 0xF go to TRAP; every other opcode goes to EXEC.
- EXEC, one cycle, by opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: SrcA = 0, SrcB = 0, AluOp = matching op, mary_write = 1 with mary_src = 0.
  - 4 ADDI: SrcB = 2, AluOp = ADD, mary_write.
  - 5 LI: mary_write with mary_src = 2.
  - 6 LW, 7 SW: SrcB = 2, AluOp = ADD, then go to MEM.
  - 8 SLT: AluOp = SLT, comp_write.
  - 9 BNZ: pc_write = comp_nonzero, pc_src = 1.
  - A JAL: ra_write with ra_src = 0, pc_write with pc_src = 1.
  - B JR: pc_write with pc_src = 2.
  - C MV: shelley_write with shelley_src = 2.
  - D ADDSP: SrcA = 1, SrcB = 3, AluOp = ADD, sp_write.
  - Overflow gating: for opcodes 0, 1, 4 with overflow = 1, mary_write is forced to 0 in that cycle and the next state is TRAP.
  - All opcodes other than 6/7 return to FETCH.
- MEM:
  - LW: mem_read = 1, mem_addr_src = 1.
  - SW: mem_write = 1, mem_addr_src = 1.
  - SrcB and AluOp are held from EXEC.
  - On mem_ready: LW goes to WB, SW goes to FETCH. Otherwise stay in MEM.
- WB: mary_write with mary_src = 1, then go to FETCH.
- Timeout: the counter is cleared on every state change. When FETCH_TIMEOUT != 0 and the counter reaches FETCH_TIMEOUT, go to TRAP.
- TRAP: halted = 1, all strobes 0. TRAP is absorbing until reset.
- Latency per instruction, with mem_ready immediate:
  - ALU, branch, jump, MV, ADDSP: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle on mem_ready adds one cycle. mem_read and mem_write are never both 1.

Decomposition:
- Package ctrl_pkg: state encoding (FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5), opcode constants, AluOp, SrcB, mary_src, shelley_src and pc_src codes. The ALU and register block share these constants.
- Optional sub-module ctrl_decode: purely combinational map from (state, opcode, overflow, comp_nonzero) to outputs. The FSM and timeout counter stay in control_fsm.

Test Plan:
- ADD, instr = 0x0000, mem_ready = 1 -> states FETCH, DECODE, EXEC. mary_write = 1 and AluOp = 0 only in EXEC. Next instruction fetch begins on cycle 4.
- LW, instr = 0x6004, mem_ready low for 3 MEM cycles -> mem_read with mem_addr_src = 1 held for 4 cycles. WB asserts mary_write with mary_src = 1. Total 8 cycles.
- ADDI with overflow = 1 in EXEC -> mary_write stays 0. Next state TRAP, halted = 1, all strobes 0 for 10 further cycles.
- Illegal instr = 0xF000 -> TRAP directly from DECODE; halted = 1. Reset pulse -> FETCH, halted = 0.
- BNZ, instr = 0x9003: with comp_nonzero = 0 -> pc_write = 0 in EXEC; with comp_nonzero = 1 -> pc_write = 1 and pc_src = 1.
- Reset asserted during MEM of SW -> mem_write drops to 0 in the cycle after reset is sampled. FETCH follows with no write completed.
